// File: rtl/taillight_sched.sv
// Rear lamp scheduler: blink prescaler, turn/hazard arbitration and 3-lamp sequencing.
// Optional brake overlay enabled by defining TAILLIGHT_BRAKE_EN.
module taillight_sched #(
    parameter int TICK_CYCLES = 33554432,
    parameter int CNT_W       = 26
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Left_req,
    input  logic       Right_req,
    input  logic       Haz_req,
`ifdef TAILLIGHT_BRAKE_EN
    input  logic       Brake,
`endif
    output logic [2:0] Left,
    output logic [2:0] Right,
    output logic [1:0] Mode,
    output logic       Tick
);

    // state | meaning
    // IDLE  | no request, both clusters dark
    // LEFT  | left cluster stepping 001->011->111->000
    // RIGHT | right cluster stepping 001->011->111->000
    // HAZ   | both clusters alternating 111/000
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        HAZ   = 2'b11
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    mode_t            mode, mode_nxt, desired;
    logic [1:0]       phase, phase_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       left_nxt, right_nxt;
    logic             brake;

`ifdef TAILLIGHT_BRAKE_EN
    assign brake = Brake;
`else
    assign brake = 1'b0;
`endif

    function automatic logic [2:0] pat(input logic [1:0] p);
        case (p)
            2'd0:    pat = 3'b000;
            2'd1:    pat = 3'b001;
            2'd2:    pat = 3'b011;
            default: pat = 3'b111;
        endcase
    endfunction

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cnt   <= '0;
            Tick  <= 1'b0;
            mode  <= IDLE;
            phase <= 2'd0;
            Left  <= 3'b000;
            Right <= 3'b000;
        end else begin
            cnt   <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            Tick  <= (cnt == CNT_LAST);
            mode  <= mode_nxt;
            phase <= phase_nxt;
            Left  <= left_nxt;
            Right <= right_nxt;
        end
    end

    assign Mode = mode;

    always_comb begin
        desired   = IDLE;
        mode_nxt  = mode;
        phase_nxt = phase;
        left_nxt  = 3'b000;
        right_nxt = 3'b000;

        if (Haz_req || (Left_req && Right_req)) desired = HAZ;
        else if (Left_req)                      desired = LEFT;
        else if (Right_req)                     desired = RIGHT;

        // Requests only matter on the step edge; otherwise everything holds.
        if (Tick) begin
            if (desired == mode) begin
                case (mode)
                    LEFT, RIGHT: phase_nxt = phase + 2'd1;
                    HAZ:         phase_nxt = ~phase;
                    default:     phase_nxt = 2'd0;
                endcase
            end else begin
                mode_nxt = desired;
                case (desired)
                    LEFT, RIGHT: phase_nxt = 2'd1;
                    HAZ:         phase_nxt = 2'd3;
                    default:     phase_nxt = 2'd0;
                endcase
            end
        end

        case (mode_nxt)
            LEFT: begin
                left_nxt  = pat(phase_nxt);
                right_nxt = brake ? 3'b111 : 3'b000;
            end
            RIGHT: begin
                left_nxt  = brake ? 3'b111 : 3'b000;
                right_nxt = pat(phase_nxt);
            end
            HAZ: begin
                left_nxt  = pat(phase_nxt);
                right_nxt = pat(phase_nxt);
            end
            default: begin
                left_nxt  = brake ? 3'b111 : 3'b000;
                right_nxt = brake ? 3'b111 : 3'b000;
            end
        endcase
    end

endmodule

// File: tb/tb_taillight_sched.sv
// Randomized scoreboard bench for taillight_sched; reference model counts cycles since reset.
module tb_taillight_sched;

    localparam int T      = 4;
    localparam int NCYC   = 3000;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Left_req = 1'b0;
    logic       Right_req = 1'b0;
    logic       Haz_req = 1'b0;
`ifdef TAILLIGHT_BRAKE_EN
    logic       brake = 1'b0;
`endif
    logic [2:0] Left, Right;
    logic [1:0] Mode;
    logic       Tick;

    taillight_sched #(.TICK_CYCLES(T), .CNT_W(3)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Left_req  (Left_req),
        .Right_req (Right_req),
        .Haz_req   (Haz_req),
`ifdef TAILLIGHT_BRAKE_EN
        .Brake     (brake),
`endif
        .Left      (Left),
        .Right     (Right),
        .Mode      (Mode),
        .Tick      (Tick)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       tick;
        logic [1:0] mode;
        logic [2:0] l;
        logic [2:0] r;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    bit   started = 0;

    // Reference state: cycles since reset release, mode as 0..3, lit-lamp count.
    int n = 0;
    int m_mode = 0;
    int m_phase = 0;

    function automatic logic [2:0] lamps(input int p);
        return 3'((1 << p) - 1);
    endfunction

    always begin
        @(posedge Clk);
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (Tick !== e.tick || Mode !== e.mode || Left !== e.l || Right !== e.r) begin
                fails++;
                $display("FAIL cycle_check t=%0t: got tick=%b mode=%b L=%b R=%b, want tick=%b mode=%b L=%b R=%b",
                         $time, Tick, Mode, Left, Right, e.tick, e.mode, e.l, e.r);
            end
        end else if (started) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_underflow t=%0t: queue empty, want 1 entry", $time);
        end
    end

    initial begin
        int   hold;
        int   desired;
        logic brk;
        exp_t e;
        hold = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge Clk);
            if (c < 3)                        Rst_n = 1'b0;
            else if ($urandom_range(0, 99) < 2) Rst_n = 1'b0;
            else                              Rst_n = 1'b1;
            if (hold == 0) begin
                Haz_req   = ($urandom_range(0, 3) == 0);
                Left_req  = $urandom_range(0, 1) == 1;
                Right_req = ($urandom_range(0, 2) == 0);
                hold      = $urandom_range(1, 16);
            end
            hold--;
            brk = 1'b0;
`ifdef TAILLIGHT_BRAKE_EN
            if ($urandom_range(0, 7) == 0) brake = ~brake;
            brk = brake;
`endif
            if (!Rst_n) begin
                n = 0; m_mode = 0; m_phase = 0;
                e.tick = 1'b0; e.mode = 2'b00; e.l = 3'b000; e.r = 3'b000;
            end else begin
                n++;
                if (n > 1 && (n - 1) % T == 0) begin
                    if (Haz_req || (Left_req && Right_req)) desired = 3;
                    else if (Left_req)                      desired = 1;
                    else if (Right_req)                     desired = 2;
                    else                                    desired = 0;
                    if (desired == m_mode) begin
                        if (m_mode == 1 || m_mode == 2) m_phase = (m_phase + 1) % 4;
                        else if (m_mode == 3)           m_phase = (m_phase == 3) ? 0 : 3;
                        else                            m_phase = 0;
                    end else begin
                        m_mode  = desired;
                        m_phase = (desired == 3) ? 3 : (desired == 0) ? 0 : 1;
                    end
                end
                e.tick = (n % T == 0);
                e.mode = 2'(m_mode);
                e.l    = (m_mode == 1 || m_mode == 3) ? lamps(m_phase) : 3'b000;
                e.r    = (m_mode == 2 || m_mode == 3) ? lamps(m_phase) : 3'b000;
                if (brk && m_mode != 3) begin
                    if (m_mode != 1) e.l = 3'b111;
                    if (m_mode != 2) e.r = 3'b111;
                end
            end
            q.push_back(e);
            started = 1;
        end
        @(posedge Clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/taillight_sched.md
Name: taillight_sched

Overview:
- Central scheduler for the rear lamp clusters.
- Owns the blink-rate prescaler.
- Arbitrates between left-turn, right-turn and hazard requests, then sequences both 3-lamp clusters (Left[2:0], Right[2:0]) through the 000→001→011→111 turn pattern or the hazard all-on/all-off pattern.
- Sits between the driver switch debouncers and the lamp drivers; replaces per-side free-running sequencers.

Parameters:
- TICK_CYCLES, default 33554432, Clk cycles per lamp step; legal range ≥2.
- CNT_W, default 26, prescaler width; must satisfy 2^CNT_W ≥ TICK_CYCLES.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- Left_req  input  1  left turn switch, level, synchronous to Clk.
- Right_req  input  1  right turn switch, level.
- Haz_req  input  1  hazard switch, level.
- Brake  input  1  brake pedal, level; present only with TAILLIGHT_BRAKE_EN.
- Left  output  3  left cluster; bit0 innermost lamp; registered.
- Right  output  3  right cluster; bit0 innermost lamp; registered.
- Mode  output  2  current mode: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZ; registered.
- Tick  output  1  one-cycle step strobe, registered.

Behaviour:
- Reset: synchronous, active-low, and takes precedence over everything else.
  - Any edge with Rst_n=0 clears the prescaler to 0 and sets Tick=0, Mode=IDLE, phase=0, Left=000, Right=000.
  - This applies mid-sequence and on a tick edge.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 and wraps to 0.
  - Tick=1 for exactly the cycle after the count equals TICK_CYCLES-1, so the period is exactly TICK_CYCLES cycles.
  - The first Tick after reset release is on the TICK_CYCLES-th edge.
- Sampling: requests are sampled only on edges where Tick=1. Between ticks, Mode, phase and the lamp outputs hold.
- Desired mode, evaluated at each tick in priority order:
  - Haz_req=1 → HAZ.
  - Left_req=1 and Right_req=1 → HAZ.
  - Left_req only → LEFT.
  - Right_req only → RIGHT.
  - Otherwise → IDLE.
- Phase: a 2-bit register, pattern P(0)=000, P(1)=001, P(2)=011, P(3)=111.
- Transition on a tick edge, desired == current mode:
  - LEFT/RIGHT: phase advances 1→2→3→0→1 (wrap 3→0 gives an all-off step).
  - HAZ: phase toggles 3↔0.
  - IDLE: phase stays 0.
- Transition on a tick edge, desired ≠ current mode (preemption, immediate at that tick, no sequence completion):
  - Mode loads the desired mode.
  - Phase loads 1 for LEFT/RIGHT, 3 for HAZ, 0 for IDLE.
- Outputs, registered on the same edge as mode/phase:
  - IDLE: Left=000, Right=000.
  - LEFT: Left=P(phase), Right=000.
  - RIGHT: Left=000, Right=P(phase).
  - HAZ: Left=Right=P(phase).
- Latency: request change to lamp change is 1..TICK_CYCLES cycles. Sub-tick request glitches are invisible.
- Boundary conditions:
  - Request released mid-sequence: IDLE (000/000) at the next tick.
  - Hazard released: the next tick enters the remaining turn request at phase 1, or IDLE.
  - Left→Right swap between ticks: RIGHT at phase 1 at the next tick; Left goes to 000 on the same edge.

Optional Feature:
- Macro: TAILLIGHT_BRAKE_EN.
- Defined: the Brake port exists and is sampled every cycle, not only at ticks. The overlay is registered, so it is visible one edge after Brake changes.
  - IDLE: Left=Right=111.
  - LEFT: Right forced to 111; Left keeps sequencing.
  - RIGHT: Left forced to 111; Right keeps sequencing.
  - HAZ: Brake ignored.
  - Releasing Brake restores the underlying pattern on the next edge.
- Undefined: no Brake port; behaviour identical to Brake=0.

Test Plan (TICK_CYCLES=4):
- Reset release, all requests 0 → Tick on edges 4, 8, 12; Left=Right=000 and Mode=00 throughout.
- Left_req=1 held → at successive ticks Left=001, 011, 111, 000, 001; Right=000; Mode=01.
- Left_req=1 sequencing; assert Haz_req while Left=011 → next tick Left=Right=111, Mode=11; following tick both 000; drop Haz_req → next tick Left=001, Mode=01.
- Left_req and Right_req both 1 → identical to hazard (both sides 111/000 alternating, Mode=11).
- Rst_n=0 for one edge while Right=111 → that edge all outputs 000, Mode=00, prescaler restarts (next Tick 4 edges after release).
- With TAILLIGHT_BRAKE_EN: Brake=1 in IDLE → Left=Right=111 one edge later; Brake=1 during LEFT → Right=111 steady while Left steps 001→011→111→000; Brake=1 during HAZ → pattern unaffected.
